cnt_event_gen: RTL



---
 rtl/cnt_event_pkg.sv | 18 +
 rtl/cnt_debounce.sv | 88 ++++++++
 rtl/cnt_event_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/cnt_event_pkg.sv
// Shared types and constants for the count-event front end.
package cnt_event_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } deb_state_e;

  localparam int DROP_W_DEFAULT = 4;
  localparam int DROP_CNT_MAX   = (1 << DROP_W_DEFAULT) - 1;

  function automatic int drop_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/cnt_debounce.sv
// Two-flop synchroniser plus debounce FSM; emits a one-cycle flag on a confirmed rise.
// state    | meaning
// LOW      | line confirmed low
// CHK_HIGH | line seen high, counting stable samples
// HIGH     | line confirmed high
// CHK_LOW  | line seen low, counting stable samples
module cnt_debounce
  import cnt_event_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic rise_o
);

  logic [1:0]       sync_q;
  logic             s;
  deb_state_e       state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             cnt_done;

  assign s        = sync_q[1];
  assign cnt_done = (cnt_q == DEB_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    unique case (state_q)
      LOW: if (s) begin
        state_d = CHK_HIGH;
        cnt_d   = DEB_W'(1);
      end
      CHK_HIGH: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      HIGH: if (!s) begin
        state_d = CHK_LOW;
        cnt_d   = DEB_W'(1);
      end
      CHK_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/cnt_event_gen.sv
// Count-control strobe generator: debounced A/B events and a clear request,
// arbitrated so at most one strobe reaches the up-counter per cycle.
module cnt_event_gen
  import cnt_event_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3,
  parameter int DROP_W     = DROP_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ev_in_a_i,
  input  logic              ev_in_b_i,
  input  logic              clr_req_i,
  output logic              up_enable_o,
  output logic              up_enable2_o,
  output logic              clear_o,
  output logic              b_pending_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(drop_max(DROP_W));

  logic              rise_a, rise_b;
  logic [1:0]        clr_sync_q;
  logic              clr_prev_q;
  logic              clr_edge;
  logic              up_q, up_d, up2_q, up2_d, clear_q, clear_d, pend_q, pend_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  cnt_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_a (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(ev_in_a_i), .rise_o(rise_a)
  );

  cnt_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_b (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(ev_in_b_i), .rise_o(rise_b)
  );

  assign clr_edge = clr_sync_q[1] & ~clr_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_sync_q <= '0;
      clr_prev_q <= 1'b0;
      up_q       <= 1'b0;
      up2_q      <= 1'b0;
      clear_q    <= 1'b0;
      pend_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      clr_sync_q <= {clr_sync_q[0], clr_req_i};
      clr_prev_q <= clr_sync_q[1];
      up_q       <= up_d;
      up2_q      <= up2_d;
      clear_q    <= clear_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  // Priority CLEAR > A > B; the single-entry queue holds a B that lost to A.
  always_comb begin
    up_d    = 1'b0;
    up2_d   = 1'b0;
    clear_d = 1'b0;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (clr_edge) begin
      clear_d = 1'b1;
      pend_d  = 1'b0;
    end else if (rise_a) begin
      up_d = 1'b1;
      if (rise_b) begin
        if (pend_q) begin
          if (drop_q != DROP_MAX) drop_d = drop_q + DROP_W'(1);
        end else begin
          pend_d = 1'b1;
        end
      end
    end else if (rise_b) begin
      up2_d = 1'b1;
    end else if (pend_q) begin
      up2_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  assign up_enable_o  = up_q;
  assign up_enable2_o = up2_q;
  assign clear_o      = clear_q;
  assign b_pending_o  = pend_q;
  assign drop_cnt_o   = drop_q;

endmodule
